inv_skew_detector: RTL and testbench

//  Feedback generator for the inverter-pair configuration loop.
//  - Repeatedly launches a race through the up (INVU) and down (INVD) inverters.
//  - Samples an analog arbiter's first-arrival result and majority-votes over NSAMP trials.
//  - Emits a one-cycle O_INVU/O_INVD decision consumed by the 4-bit config block.
//  - Declares LOCKED once the loop dithers or lands in the dead band.

---
 rtl/skew_cal_pkg.sv | 23 ++
 rtl/skew_sync2.sv | 25 ++
 rtl/inv_skew_detector.sv | 158 +++++++++++++++
 tb/tb_inv_skew_detector.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_cal_pkg.sv
// skew_cal_pkg: shared state encoding, decision codes and majority-vote helper for the skew calibration loop
package skew_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_SAMPLE,
        ST_RECOVER,
        ST_DECIDE
    } state_t;

    localparam logic [1:0] DEC_UP   = 2'b10;
    localparam logic [1:0] DEC_DN   = 2'b01;
    localparam logic [1:0] DEC_NONE = 2'b00;

    // A side wins only when it clears half the trials by more than the dead band
    function automatic logic [1:0] vote_decision(input int up, input int nsamp, input int margin);
        return (up > nsamp / 2 + margin) ? DEC_UP :
               (nsamp - up > nsamp / 2 + margin) ? DEC_DN : DEC_NONE;
    endfunction

endpackage

// File: rtl/skew_sync2.sv
// skew_sync2: two-flop synchroniser for one asynchronous arbiter bit
//   CLK   in  clock
//   RST_N in  synchronous reset, active low
//   d     in  asynchronous input
//   q     out synchronised output
module skew_sync2 (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inv_skew_detector.sv
// inv_skew_detector: races the INVU/INVD inverters, majority-votes the arbiter and emits up/down decisions
//   CLK    in  clock
//   RST_N  in  synchronous reset, active low
//   EN     in  calibration enable (level; rising edge starts a run)
//   RACE_U in  async arbiter: INVU edge first
//   RACE_D in  async arbiter: INVD edge first
//   LAUNCH out race edge to both inverters (low = recover)
//   O_INVU out one-cycle decision pulse, INVU won
//   O_INVD out one-cycle decision pulse, INVD won
//   LOCKED out sticky, calibration converged
//   ERR    out sticky, too many consecutive invalid trials
module inv_skew_detector
    import skew_cal_pkg::*;
#(
    parameter int NSAMP      = 16,
    parameter int SETTLE     = 4,
    parameter int MARGIN     = 2,
    parameter int DITHER_LIM = 4,
    parameter int INV_LIM    = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    input  logic RACE_U,
    input  logic RACE_D,
    output logic LAUNCH,
    output logic O_INVU,
    output logic O_INVD,
    output logic LOCKED,
    output logic ERR
);

    localparam int CW = $clog2(NSAMP) + 1;
    localparam int TW = $clog2(SETTLE + 1);
    localparam int FW = $clog2(DITHER_LIM + 1);
    localparam int IW = $clog2(INV_LIM + 1);

    state_t        state;
    logic          en_q;
    logic          race_u_s;
    logic          race_d_s;
    logic [CW-1:0] up_votes;
    logic [CW-1:0] trials;
    logic [TW-1:0] timer;
    logic [FW-1:0] flips;
    logic [IW-1:0] invalids;
    logic [1:0]    last_dir;
    logic [1:0]    dec;
    logic          reversal;
    logic          lock;

    skew_sync2 u_sync_u (.CLK(CLK), .RST_N(RST_N), .d(RACE_U), .q(race_u_s));
    skew_sync2 u_sync_d (.CLK(CLK), .RST_N(RST_N), .d(RACE_D), .q(race_d_s));

    // Lock on a dead-band result or on the reversal that reaches the dither limit
    always_comb begin
        dec      = vote_decision(int'(up_votes), NSAMP, MARGIN);
        reversal = dec != DEC_NONE && last_dir != DEC_NONE && dec != last_dir;
        lock     = dec == DEC_NONE || (reversal && flips == FW'(DITHER_LIM - 1));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            en_q     <= 1'b0;
            LAUNCH   <= 1'b0;
            O_INVU   <= 1'b0;
            O_INVD   <= 1'b0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            up_votes <= '0;
            trials   <= '0;
            timer    <= '0;
            flips    <= '0;
            invalids <= '0;
            last_dir <= DEC_NONE;
        end else begin
            en_q   <= EN;
            O_INVU <= 1'b0;
            O_INVD <= 1'b0;
            if (!EN) begin
                state    <= ST_IDLE;
                LAUNCH   <= 1'b0;
                up_votes <= '0;
                trials   <= '0;
                timer    <= '0;
                flips    <= '0;
                invalids <= '0;
                last_dir <= DEC_NONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Only a fresh EN edge restarts; a held EN after lock/error stays parked
                        if (!en_q) begin
                            LOCKED   <= 1'b0;
                            ERR      <= 1'b0;
                            up_votes <= '0;
                            trials   <= '0;
                            flips    <= '0;
                            invalids <= '0;
                            last_dir <= DEC_NONE;
                            LAUNCH   <= 1'b1;
                            state    <= ST_LAUNCH;
                        end
                    end
                    ST_LAUNCH: begin
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (timer == TW'(SETTLE - 1)) state <= ST_SAMPLE;
                        else timer <= timer + 1'b1;
                    end
                    ST_SAMPLE: begin
                        timer  <= '0;
                        LAUNCH <= 1'b0;
                        if (race_u_s != race_d_s) begin
                            up_votes <= up_votes + CW'(race_u_s);
                            trials   <= trials + 1'b1;
                            invalids <= '0;
                            state    <= ST_RECOVER;
                        end else if (invalids == IW'(INV_LIM - 1)) begin
                            invalids <= IW'(INV_LIM);
                            ERR      <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            invalids <= invalids + 1'b1;
                            state    <= ST_RECOVER;
                        end
                    end
                    ST_RECOVER: begin
                        if (timer != TW'(SETTLE - 1)) timer <= timer + 1'b1;
                        else if (trials == CW'(NSAMP)) state <= ST_DECIDE;
                        else begin
                            LAUNCH <= 1'b1;
                            state  <= ST_LAUNCH;
                        end
                    end
                    ST_DECIDE: begin
                        {O_INVU, O_INVD} <= dec;
                        if (dec != DEC_NONE) last_dir <= dec;
                        if (reversal && flips != FW'(DITHER_LIM)) flips <= flips + 1'b1;
                        if (lock) LOCKED <= 1'b1;
                        up_votes <= '0;
                        trials   <= '0;
                        LAUNCH   <= !lock;
                        state    <= lock ? ST_IDLE : ST_LAUNCH;
                    end
                    default: begin
                        LAUNCH <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inv_skew_detector.sv
// tb_inv_skew_detector: self-checking bench with an arbiter model driven per trial and a rule-level reference
module tb_inv_skew_detector;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic EN = 1'b0;
    logic RACE_U = 1'b0;
    logic RACE_D = 1'b0;
    logic LAUNCH, O_INVU, O_INVD, LOCKED, ERR;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic lprev = 1'b0;
    logic both_seen = 1'b0;
    logic [1:0] dflt = 2'b11;
    logic [1:0] plan[$];
    int rises[$];
    int pcyc[$];
    logic [1:0] pcode[$];
    int exp_cyc[$];
    logic [1:0] exp_code[$];
    int eend;
    logic elock, eerr;

    typedef struct {
        int up;
        logic [1:0] code;
        logic lock;
    } vec_t;
    vec_t vecs[6];

    inv_skew_detector dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .RACE_U(RACE_U), .RACE_D(RACE_D),
        .LAUNCH(LAUNCH), .O_INVU(O_INVU), .O_INVD(O_INVD), .LOCKED(LOCKED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Arbiter model: a new outcome is presented on every rising LAUNCH and held through the trial
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (LAUNCH && !lprev) begin
            rises.push_back(cyc);
            if (plan.size() > 0) {RACE_U, RACE_D} = plan.pop_front();
            else {RACE_U, RACE_D} = dflt;
        end
        lprev = LAUNCH;
        if (O_INVU || O_INVD) begin
            pcyc.push_back(cyc);
            pcode.push_back({O_INVU, O_INVD});
        end
        if (O_INVU && O_INVD) both_seen = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int rel();
        return rises.size() > 0 ? cyc - rises[0] : -1;
    endfunction

    task automatic start();
        EN = 1'b0;
        tick(2);
        rises.delete();
        pcyc.delete();
        pcode.delete();
        EN = 1'b1;
        tick(1);
    endtask

    task automatic wait_rel(input int r, input string name);
        int n = 0;
        while (rel() < r && n < 3000) begin
            tick(1);
            n++;
        end
        if (rel() != r) chk({name, "_reach"}, rel(), r);
    endtask

    task automatic run_end(output int r);
        int n = 0;
        while (!(LOCKED === 1'b1 || ERR === 1'b1) && n < 4000) begin
            tick(1);
            n++;
        end
        r = rel();
    endtask

    task automatic fill_block(input int up);
        for (int i = 0; i < 16; i++) plan.push_back(i < up ? 2'b10 : 2'b01);
    endtask

    // Reference: every trial costs 10 cycles, a decision adds 1; pulse appears as the block ends
    task automatic model();
        int t = 0, valid = 0, up = 0, inv = 0, flips = 0;
        logic [1:0] last = 2'b00, o, code;
        exp_cyc.delete();
        exp_code.delete();
        elock = 1'b0;
        eerr = 1'b0;
        eend = -1;
        for (int i = 0; i < 3000 && !elock && !eerr; i++) begin
            o = i < plan.size() ? plan[i] : dflt;
            t += 10;
            if (o == 2'b10 || o == 2'b01) begin
                valid++;
                if (o == 2'b10) up++;
                inv = 0;
            end else begin
                inv++;
                if (inv == 8) begin
                    eerr = 1'b1;
                    eend = t - 4;
                end
            end
            if (valid == 16) begin
                t += 1;
                code = up > 10 ? 2'b10 : (16 - up > 10 ? 2'b01 : 2'b00);
                if (code != 2'b00) begin
                    exp_cyc.push_back(t);
                    exp_code.push_back(code);
                    if (last != 2'b00 && code != last) begin
                        flips++;
                        if (flips == 4) elock = 1'b1;
                    end
                    last = code;
                end else elock = 1'b1;
                eend = t;
                valid = 0;
                up = 0;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        vecs[0] = '{16, 2'b10, 1'b0};
        vecs[1] = '{11, 2'b10, 1'b0};
        vecs[2] = '{10, 2'b00, 1'b1};
        vecs[3] = '{6, 2'b00, 1'b1};
        vecs[4] = '{5, 2'b01, 1'b0};
        vecs[5] = '{0, 2'b01, 1'b0};

        // Reset and idle
        tick(3);
        chk("rst_launch", LAUNCH, 0);
        chk("rst_dec", {O_INVU, O_INVD}, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_err", ERR, 0);
        RST_N = 1'b1;
        tick(6);
        chk("idle_no_launch", rises.size(), 0);

        // Single-block voting boundaries
        foreach (vecs[v]) begin
            plan.delete();
            fill_block(vecs[v].up);
            dflt = 2'b11;
            start();
            wait_rel(160, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_pre", v), {O_INVU, O_INVD}, 0);
            tick(1);
            chk($sformatf("vec%0d_dec", v), {O_INVU, O_INVD}, vecs[v].code);
            chk($sformatf("vec%0d_lock", v), LOCKED, vecs[v].lock);
        end

        // Steady up: pulses every 161 cycles
        plan.delete();
        dflt = 2'b10;
        start();
        for (int n = 0; n < 700 && pcyc.size() < 3; n++) tick(1);
        chk("up_count", pcyc.size(), 3);
        for (int k = 0; k < 3 && k < pcyc.size(); k++) begin
            chk($sformatf("up_t%0d", k), pcyc[k] - rises[0], 161 * (k + 1));
            chk($sformatf("up_c%0d", k), pcode[k], 2);
        end
        chk("up_nolock", LOCKED, 0);

        // Dither 12/4 alternating until lock
        plan.delete();
        for (int b = 0; b < 5; b++) fill_block(b % 2 == 0 ? 12 : 4);
        dflt = 2'b11;
        start();
        run_end(r);
        chk("dith_end", r, 805);
        chk("dith_lock", LOCKED, 1);
        chk("dith_count", pcode.size(), 5);
        for (int k = 0; k < 5 && k < pcode.size(); k++) begin
            chk($sformatf("dith_c%0d", k), pcode[k], k % 2 == 0 ? 2 : 1);
            chk($sformatf("dith_t%0d", k), pcyc[k] - rises[0], 161 * (k + 1));
        end
        tick(30);
        chk("dith_quiet", LAUNCH, 0);
        chk("dith_launches", rises.size(), 80);

        // Invalid arbiter: ERR after 8 samples, cleared by EN edge
        plan.delete();
        dflt = 2'b11;
        start();
        run_end(r);
        chk("err_set", ERR, 1);
        chk("err_time", r, 76);
        chk("err_nopulse", pcyc.size(), 0);
        chk("err_launch", LAUNCH, 0);
        EN = 1'b0;
        tick(2);
        chk("err_kept", ERR, 1);
        EN = 1'b1;
        tick(1);
        chk("err_clear", ERR, 0);
        chk("err_restart", LAUNCH, 1);

        // EN dropped in trial 7, then restart must count from zero
        plan.delete();
        dflt = 2'b10;
        start();
        for (int n = 0; n < 200 && rises.size() < 7; n++) tick(1);
        tick(2);
        EN = 1'b0;
        tick(1);
        chk("drop_launch", LAUNCH, 0);
        chk("drop_dec", {O_INVU, O_INVD}, 0);
        plan.delete();
        fill_block(10);
        dflt = 2'b11;
        start();
        run_end(r);
        chk("drop_relock_t", r, 161);
        chk("drop_relock", LOCKED, 1);
        chk("drop_nopulse", pcyc.size(), 0);

        // Reset during DECIDE suppresses the pulse
        plan.delete();
        dflt = 2'b10;
        start();
        wait_rel(160, "rstdec");
        RST_N = 1'b0;
        tick(1);
        chk("rstdec_dec", {O_INVU, O_INVD}, 0);
        chk("rstdec_launch", LAUNCH, 0);
        chk("rstdec_nopulse", pcyc.size(), 0);
        tick(1);
        rises.delete();
        pcyc.delete();
        pcode.delete();
        RST_N = 1'b1;
        tick(1);
        wait_rel(161, "rstdec_re");
        chk("rstdec_re_dec", {O_INVU, O_INVD}, 2);

        // Randomised runs against the rule-level model
        for (int rd = 0; rd < 3; rd++) begin
            int bias, x;
            plan.delete();
            for (int s = 0; s < 6; s++) begin
                bias = $urandom_range(0, 2);
                for (int i = 0; i < 20; i++) begin
                    x = $urandom_range(0, 15);
                    if (x < 2) plan.push_back(x == 0 ? 2'b00 : 2'b11);
                    else if (bias == 0) plan.push_back($urandom_range(0, 15) < 14 ? 2'b10 : 2'b01);
                    else if (bias == 1) plan.push_back($urandom_range(0, 15) < 2 ? 2'b10 : 2'b01);
                    else plan.push_back($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
                end
            end
            dflt = 2'b11;
            model();
            start();
            run_end(r);
            chk($sformatf("rnd%0d_end", rd), r, eend);
            chk($sformatf("rnd%0d_lock", rd), LOCKED, elock);
            chk($sformatf("rnd%0d_err", rd), ERR, eerr);
            chk($sformatf("rnd%0d_count", rd), pcyc.size(), exp_cyc.size());
            for (int i = 0; i < exp_cyc.size() && i < pcyc.size(); i++) begin
                chk($sformatf("rnd%0d_t%0d", rd, i), pcyc[i] - rises[0], exp_cyc[i]);
                chk($sformatf("rnd%0d_c%0d", rd, i), pcode[i], exp_code[i]);
            end
            tick(20);
            chk($sformatf("rnd%0d_quiet", rd), LAUNCH, 0);
        end

        chk("never_both", both_seen, 0);
        EN = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
